// File: rtl/vvi_pacemaker_array.sv
// N-channel VVI pacemaker sharing one tick prescaler; sense-to-state and expiry-to-pace take 1 cycle.
// All outputs are registered one-cycle pulses; there is no backpressure, since events are fire-and-forget.
module vvi_pacemaker_array #(
  parameter int N_CHANNELS = 4,
  parameter int TICK_DIV   = 50000,
  parameter int LRI_MS     = 1000,
  parameter int VRP_MS     = 300,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CHANNELS-1:0] chan_en,
  input  logic [N_CHANNELS-1:0] VPulse_eI,
  output logic [N_CHANNELS-1:0] VPace_eO,
  output logic [N_CHANNELS-1:0] VRefractory_eO,
  output logic                  tick_o
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] LRI_LAST   = CNT_W'(LRI_MS - 1);
  localparam logic [CNT_W-1:0] VRP_LAST   = CNT_W'(VRP_MS - 1);
  localparam logic [CNT_W-1:0] VRP_CNT    = CNT_W'(VRP_MS);

  typedef enum logic {ALERT = 1'b0, REFRACT = 1'b1} state_t;

  logic [PW-1:0]         r_presc;
  logic                  r_tick;
  logic [N_CHANNELS-1:0] r_pace;
  logic [N_CHANNELS-1:0] r_refr;
  state_t                r_state [N_CHANNELS];
  logic [CNT_W-1:0]      r_cnt   [N_CHANNELS];
  logic                  w_tick;

  assign w_tick         = (r_presc == PRESC_LAST);
  assign tick_o         = r_tick;
  assign VPace_eO       = r_pace;
  assign VRefractory_eO = r_refr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_pace  <= '0;
      r_refr  <= '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
        r_state[i] <= ALERT;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_tick  <= w_tick;
      for (int i = 0; i < N_CHANNELS; i++) begin
        r_pace[i] <= 1'b0;
        r_refr[i] <= 1'b0;
        if (!chan_en[i]) begin
          r_state[i] <= ALERT;
          r_cnt[i]   <= '0;
        end else begin
          case (r_state[i])
            ALERT: begin
              // A sense wins over a simultaneous LRI expiry: the pace is inhibited.
              if (VPulse_eI[i]) begin
                r_state[i] <= REFRACT;
                r_cnt[i]   <= '0;
              end else if (w_tick && (r_cnt[i] == LRI_LAST)) begin
                r_pace[i]  <= 1'b1;
                r_state[i] <= REFRACT;
                r_cnt[i]   <= '0;
              end else if (w_tick) begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
              end
            end
            REFRACT: begin
              r_refr[i] <= VPulse_eI[i];
              // Count keeps running through VRP so LRI is measured from the last event.
              if (w_tick && (r_cnt[i] == VRP_LAST)) begin
                r_state[i] <= ALERT;
                r_cnt[i]   <= VRP_CNT;
              end else if (w_tick) begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
              end
            end
            default: begin
              r_state[i] <= ALERT;
              r_cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_vvi_pacemaker_array.sv
// Scoreboard bench for vvi_pacemaker_array: a behavioural model queues expected outputs per edge.
module tb_vvi_pacemaker_array;

  localparam int NC  = 4;
  localparam int TD  = 2;
  localparam int LRI = 10;
  localparam int VRP = 3;

  logic          clk;
  logic          reset;
  logic [NC-1:0] chan_en;
  logic [NC-1:0] VPulse_eI;
  logic [NC-1:0] VPace_eO;
  logic [NC-1:0] VRefractory_eO;
  logic          tick_o;

  vvi_pacemaker_array #(
    .N_CHANNELS(NC), .TICK_DIV(TD), .LRI_MS(LRI), .VRP_MS(VRP), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .chan_en(chan_en), .VPulse_eI(VPulse_eI),
    .VPace_eO(VPace_eO), .VRefractory_eO(VRefractory_eO), .tick_o(tick_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC-1:0] pace;
    logic [NC-1:0] refr;
    logic          tick;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  int   m_presc;
  bit   m_refract [NC];
  int   m_cnt     [NC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Reference behaviour written from the channel description, one clock edge at a time.
  task automatic model_update();
    exp_t e;
    bit   tk;
    e = '0;
    if (reset) begin
      m_presc = 0;
      for (int c = 0; c < NC; c++) begin
        m_refract[c] = 1'b0;
        m_cnt[c]     = 0;
      end
    end else begin
      tk      = (m_presc == TD - 1);
      m_presc = tk ? 0 : m_presc + 1;
      e.tick  = tk;
      for (int c = 0; c < NC; c++) begin
        if (!chan_en[c]) begin
          m_refract[c] = 1'b0;
          m_cnt[c]     = 0;
        end else if (!m_refract[c]) begin
          if (VPulse_eI[c]) begin
            m_refract[c] = 1'b1;
            m_cnt[c]     = 0;
          end else if (tk) begin
            if (m_cnt[c] + 1 == LRI) begin
              e.pace[c]    = 1'b1;
              m_refract[c] = 1'b1;
              m_cnt[c]     = 0;
            end else begin
              m_cnt[c]++;
            end
          end
        end else begin
          if (VPulse_eI[c]) e.refr[c] = 1'b1;
          if (tk) begin
            if (m_cnt[c] + 1 == VRP) begin
              m_refract[c] = 1'b0;
              m_cnt[c]     = VRP;
            end else begin
              m_cnt[c]++;
            end
          end
        end
      end
    end
    q.push_back(e);
  endtask

  task automatic step();
    exp_t ex;
    @(posedge clk);
    cyc++;
    model_update();
    #1;
    ex = q.pop_front();
    chk("pace", 32'(VPace_eO), 32'(ex.pace));
    chk("refr", 32'(VRefractory_eO), 32'(ex.refr));
    chk("tick", 32'(tick_o), 32'(ex.tick));
    chk("pace_refr_excl", 32'(|(VPace_eO & VRefractory_eO)), 32'd0);
  endtask

  task automatic wait_pace(input int ch, output int at);
    at = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (VPace_eO[ch]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("pace_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int last [NC];
    int p, p2, t_ev, d, dis_out;

    reset     = 1'b1;
    chan_en   = '1;
    VPulse_eI = '0;
    step();
    step();
    chk("rst_out", {27'd0, VPace_eO, tick_o}, 32'd0);
    chk("rst_refr", 32'(VRefractory_eO), 32'd0);
    reset = 1'b0;

    // 1: free-running, all channels pace together every LRI*TD cycles
    for (int c = 0; c < NC; c++) last[c] = -1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (VPace_eO != '0) chk("t1_sync", 32'(VPace_eO), 32'hF);
      for (int c = 0; c < NC; c++) begin
        if (VPace_eO[c]) begin
          if (last[c] >= 0) chk("t1_gap", 32'(cyc - last[c]), 32'd20);
          last[c] = cyc;
        end
      end
    end

    // 2: sense in ALERT restarts ch1's interval
    wait_pace(1, p);
    for (int k = 0; k < 9; k++) step();
    VPulse_eI[1] = 1'b1;
    step();
    t_ev = cyc;
    VPulse_eI[1] = 1'b0;
    wait_pace(1, p2);
    chk("t2_delay", 32'(p2 - t_ev), 32'd20);

    // 3: sense during VRP flags refractory and leaves timing alone
    wait_pace(2, p);
    for (int k = 0; k < 3; k++) step();
    VPulse_eI[2] = 1'b1;
    step();
    VPulse_eI[2] = 1'b0;
    chk("t3_refr", 32'(VRefractory_eO[2]), 32'd1);
    wait_pace(2, p2);
    chk("t3_period", 32'(p2 - p), 32'd20);

    // 4: sense on the expiry tick inhibits the pace
    wait_pace(3, p);
    for (int k = 0; k < 19; k++) step();
    VPulse_eI[3] = 1'b1;
    step();
    VPulse_eI[3] = 1'b0;
    chk("t4_nopace", 32'(VPace_eO[3]), 32'd0);
    wait_pace(3, p2);
    chk("t4_delay", 32'(p2 - p), 32'd40);

    // 5: mid-interval reset
    for (int k = 0; k < 7; k++) step();
    reset = 1'b1;
    step();
    t_ev = cyc;
    reset = 1'b0;
    chk("t5_rst_out", {23'd0, VPace_eO, VRefractory_eO, tick_o}, 32'd0);
    wait_pace(0, p);
    chk("t5_delay", 32'(p - t_ev), 32'd20);
    chk("t5_all", 32'(VPace_eO), 32'hF);

    // 6: disabled channel ignores pulses and restarts on re-enable
    chan_en[0] = 1'b0;
    dis_out = 0;
    for (int k = 0; k < 50; k++) begin
      VPulse_eI[0] = (k % 5 == 2);
      step();
      dis_out += int'(VPace_eO[0] | VRefractory_eO[0]);
    end
    VPulse_eI[0] = 1'b0;
    chk("t6_quiet", 32'(dis_out), 32'd0);
    chan_en[0] = 1'b1;
    step();
    t_ev = cyc;
    wait_pace(0, p);
    d = p - t_ev;
    chk("t6_delay_window", 32'(d >= 18 && d <= 22), 32'd1);

    for (int k = 0; k < 5; k++) step();
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
